shake_key_loader: RTL and testbench

- Initiator/host side of the SHAKE128 stream interface; drives the core's absorb port and consumes its squeeze port.
- On i_start, latches a seed and streams it as 64-bit words with valid/last, honouring the core's ready.
- Then waits for squeezed output, captures NUM_KEYS 128-bit keys, acknowledging each one.
- Presents each key with a one-cycle strobe to the AES-CBC datapath key mux.

---
 rtl/shake_key_loader.sv | 129 ++++++++++++
 tb/tb_shake_key_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shake_key_loader.sv
// shake_key_loader: streams a latched seed into the SHAKE128 core, then captures squeezed 128-bit keys
module shake_key_loader #(
  parameter int SEED_WORDS = 4,
  parameter int NUM_KEYS   = 1,
  parameter int TIMEOUT    = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic [64*SEED_WORDS-1:0]  i_seed,
  output logic [63:0]               o_shake_data,
  output logic                      o_shake_valid,
  output logic                      o_shake_last,
  input  logic                      i_shake_ready,
  input  logic [127:0]              i_shake_out,
  input  logic                      i_shake_out_valid,
  input  logic                      i_squeeze_mode,
  output logic                      o_shake_ack,
  output logic [127:0]              o_key,
  output logic                      o_key_valid,
  output logic [3:0]                o_key_idx,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err
);
  localparam logic [3:0]  LAST_W = 4'(SEED_WORDS - 1);
  localparam logic [4:0]  KEYS   = 5'(NUM_KEYS);
  localparam logic [15:0] TO_MAX = 16'(TIMEOUT - 1);
  typedef enum logic [2:0] {S_IDLE, S_ABSORB, S_WAIT_SQ, S_ACK, S_DROP, S_DONE} state_t;
  state_t                    r_state;
  logic [64*SEED_WORDS-1:0]  r_seed;
  logic [3:0]                r_w;
  logic [4:0]                r_keys;
  logic [15:0]               r_to;
  logic                      w_xfer;
  logic                      w_cap;
  logic                      w_to;
  assign w_xfer = o_shake_valid & i_shake_ready;
  assign w_cap  = i_shake_out_valid & i_squeeze_mode;
  assign w_to   = r_to == TO_MAX;
  // The seed shifts down one word per transfer, so the absorb word is always its low 64 bits
  // and reads as zero once the stream has drained.
  assign o_shake_data = r_seed[63:0];
  // Request sequencer: absorb the seed, then capture and acknowledge NUM_KEYS squeezed blocks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_seed        <= '0;
      r_w           <= '0;
      r_keys        <= '0;
      r_to          <= '0;
      o_shake_valid <= 1'b0;
      o_shake_last  <= 1'b0;
      o_shake_ack   <= 1'b0;
      o_key         <= '0;
      o_key_valid   <= 1'b0;
      o_key_idx     <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_shake_ack <= 1'b0;
      o_key_valid <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_seed        <= i_seed;
          r_w           <= '0;
          r_keys        <= '0;
          r_to          <= '0;
          o_shake_valid <= 1'b1;
          o_shake_last  <= LAST_W == 4'd0;
          o_busy        <= 1'b1;
          r_state       <= S_ABSORB;
        end
        S_ABSORB: if (w_xfer) begin
          r_seed       <= r_seed >> 64;
          r_w          <= r_w + 4'd1;
          o_shake_last <= (r_w + 4'd1) == LAST_W;
          if (o_shake_last) begin
            o_shake_valid <= 1'b0;
            o_shake_last  <= 1'b0;
            r_to          <= '0;
            r_state       <= S_WAIT_SQ;
          end
        end
        S_WAIT_SQ: if (w_cap) begin
          o_key       <= i_shake_out;
          o_shake_ack <= 1'b1;
          o_key_valid <= 1'b1;
          o_key_idx   <= r_keys[3:0];
          r_state     <= S_ACK;
        end else if (w_to) begin
          o_err   <= 1'b1;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end else begin
          r_to <= r_to + 16'd1;
        end
        S_ACK: begin
          r_keys  <= r_keys + 5'd1;
          r_to    <= '0;
          r_state <= S_DROP;
        end
        S_DROP: if (!i_shake_out_valid) begin
          if (r_keys == KEYS) begin
            o_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_to    <= '0;
            r_state <= S_WAIT_SQ;
          end
        end else if (w_to) begin
          o_err   <= 1'b1;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end else begin
          r_to <= r_to + 16'd1;
        end
        S_DONE: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shake_key_loader.sv
// tb_shake_key_loader: randomized scoreboard bench for the SHAKE seed/key loader
module tb_shake_key_loader;
  localparam int SW = 4;
  localparam int NK = 3;
  localparam int TO = 16;
  logic           i_clk = 1'b0;
  logic           i_rst_n = 1'b0;
  logic           i_start = 1'b0;
  logic [64*SW-1:0] i_seed = '0;
  logic [63:0]    o_shake_data;
  logic           o_shake_valid, o_shake_last;
  logic           i_shake_ready = 1'b0;
  logic [127:0]   i_shake_out = '0;
  logic           i_shake_out_valid = 1'b0;
  logic           i_squeeze_mode = 1'b0;
  logic           o_shake_ack;
  logic [127:0]   o_key;
  logic           o_key_valid;
  logic [3:0]     o_key_idx;
  logic           o_busy, o_done, o_err;

  shake_key_loader #(.SEED_WORDS(SW), .NUM_KEYS(NK), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_seed(i_seed),
    .o_shake_data(o_shake_data), .o_shake_valid(o_shake_valid), .o_shake_last(o_shake_last),
    .i_shake_ready(i_shake_ready), .i_shake_out(i_shake_out), .i_shake_out_valid(i_shake_out_valid),
    .i_squeeze_mode(i_squeeze_mode), .o_shake_ack(o_shake_ack), .o_key(o_key),
    .o_key_valid(o_key_valid), .o_key_idx(o_key_idx), .o_busy(o_busy), .o_done(o_done), .o_err(o_err));

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_last = 0;
  int n_done = 0, n_err = 0, n_xfer = 0;
  logic [64:0]  exp_w[$];
  logic [131:0] exp_k[$];
  logic [127:0] last_key = '0;
  logic [3:0]   pat = 4'b1001;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  always @(posedge i_clk) cyc <= cyc + 1;

  // Absorb monitor: each handshake must deliver the next expected seed word; stalled words stay put.
  logic [63:0] m_pd;
  logic        m_pl, m_pstall = 1'b0;
  logic [64:0] m_ew;
  always @(negedge i_clk) begin
    if (!i_rst_n) m_pstall = 1'b0;
    else begin
      if (m_pstall) begin
        chk("hold_valid", o_shake_valid, 1);
        chk("hold_data", o_shake_data, m_pd);
        chk("hold_last", o_shake_last, m_pl);
      end
      m_pstall = o_shake_valid && !i_shake_ready;
      m_pd = o_shake_data;
      m_pl = o_shake_last;
      if (o_shake_valid && i_shake_ready) begin
        n_xfer++;
        if (exp_w.size() == 0) begin
          checks++; errors++;
          $display("FAIL absorb_extra: got word %0h expected no transfer", o_shake_data);
        end else begin
          m_ew = exp_w.pop_front();
          chk("absorb_data", o_shake_data, m_ew[63:0]);
          chk("absorb_last", o_shake_last, m_ew[64]);
          if (o_shake_last) t_last = cyc;
        end
      end
    end
  end

  // Key monitor: every strobe must match the next block the core offered in squeeze mode.
  logic [131:0] m_ek;
  always @(negedge i_clk) begin
    if (i_rst_n && (o_key_valid || o_shake_ack)) begin
      chk("ack_with_key_valid", o_shake_ack, o_key_valid);
      if (o_key_valid) begin
        if (exp_k.size() == 0) begin
          checks++; errors++;
          $display("FAIL key_extra: got key %0h idx %0d expected no capture", o_key, o_key_idx);
        end else begin
          m_ek = exp_k.pop_front();
          chk("key", o_key, m_ek[127:0]);
          chk("key_idx", o_key_idx, m_ek[131:128]);
        end
      end
    end
  end

  // Pulse monitor: count completions and aborts; an abort must land TO cycles into WAIT_SQ.
  always @(negedge i_clk) begin
    if (i_rst_n && o_done) n_done++;
    if (i_rst_n && o_err) begin
      n_err++;
      chk("timeout_latency", cyc - t_last, TO + 1);
    end
  end

  task automatic do_start(input logic [255:0] seed);
    @(posedge i_clk); #1;
    i_seed = seed; i_start = 1'b1; i_shake_ready = 1'b0;
    for (int w = 0; w < SW; w++) exp_w.push_back({w == SW - 1, seed[64*w +: 64]});
    @(posedge i_clk); #1;
    i_start = 1'b0;
    @(negedge i_clk);
    chk("start_valid", o_shake_valid, 1);
    chk("start_busy", o_busy, 1);
    chk("start_data", o_shake_data, seed[63:0]);
    chk("start_keeps_key", o_key, last_key);
  endtask

  task automatic absorb(input bit use_pat);
    bit fin = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge i_clk); #1;
      i_shake_ready = use_pat ? pat[c % 4] : 1'($urandom_range(0, 1));
      @(negedge i_clk);
      if (o_shake_valid && i_shake_ready && o_shake_last) begin fin = 1; break; end
    end
    chk("absorb_finished", fin, 1);
  endtask

  task automatic deliver(input logic [127:0] k, input int idx, input int pre, input int post);
    bit got = 0;
    repeat (pre) @(posedge i_clk);
    @(posedge i_clk); #1;
    i_shake_ready = 1'b0;
    i_shake_out = k; i_shake_out_valid = 1'b1; i_squeeze_mode = 1'b1;
    exp_k.push_back({4'(idx), k});
    last_key = k;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (o_shake_ack) begin got = 1; break; end
    end
    chk("ack_seen", got, 1);
    repeat (post) @(posedge i_clk);
    @(posedge i_clk); #1;
    i_shake_out_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge i_clk);
      if (!o_busy) begin ok = 1; break; end
    end
    chk("idle_reached", ok, 1);
    @(negedge i_clk);
  endtask

  task automatic full_request(input logic [255:0] seed);
    int d0 = n_done, e0 = n_err;
    do_start(seed);
    absorb(0);
    for (int k = 0; k < NK; k++)
      deliver({$urandom, $urandom, $urandom, $urandom}, k, $urandom_range(0, 4), $urandom_range(0, 3));
    wait_idle();
    chk("req_done_cnt", n_done - d0, 1);
    chk("req_err_cnt", n_err - e0, 0);
    chk("req_words_left", exp_w.size(), 0);
    chk("req_keys_left", exp_k.size(), 0);
    chk("req_final_key", o_key, last_key);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0, e0, x0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_flags", {o_shake_valid, o_shake_last, o_shake_ack, o_key_valid, o_busy, o_done, o_err}, 0);
    chk("rst_key", o_key, 0);
    chk("rst_data", o_shake_data, 0);
    chk("rst_idx", o_key_idx, 0);

    // Directed request: backpressured absorb, three keys, ignored start and mode-0 block mid-request.
    d0 = n_done; e0 = n_err; x0 = n_xfer;
    do_start(256'h0404040404040404_0303030303030303_0202020202020202_0101010101010101);
    absorb(1);
    deliver(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 0, 1);
    @(posedge i_clk); #1;
    i_start = 1'b1; i_seed = rnd256();
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_shake_out = 128'hdeadbeef_00112233_44556677_8899aabb;
    i_shake_out_valid = 1'b1; i_squeeze_mode = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_shake_out_valid = 1'b0;
    deliver(128'h00112233445566778899aabbccddeeff, 1, 1, 0);
    deliver(128'hfedcba9876543210fedcba9876543210, 2, 2, 3);
    wait_idle();
    chk("a_xfer_cnt", n_xfer - x0, SW);
    chk("a_done_cnt", n_done - d0, 1);
    chk("a_err_cnt", n_err - e0, 0);
    chk("a_words_left", exp_w.size(), 0);
    chk("a_keys_left", exp_k.size(), 0);

    // Randomized requests.
    for (int r = 0; r < 3; r++) full_request(rnd256());

    // Timeout: the core never produces squeeze output.
    d0 = n_done; e0 = n_err;
    do_start(rnd256());
    absorb(0);
    wait_idle();
    chk("to_err_cnt", n_err - e0, 1);
    chk("to_done_cnt", n_done - d0, 0);
    chk("to_busy", o_busy, 0);
    chk("to_key_held", o_key, last_key);

    // Reset while two of four words have been absorbed.
    do_start(rnd256());
    @(posedge i_clk); #1 i_shake_ready = 1'b1;
    @(posedge i_clk);
    @(posedge i_clk); #1 i_shake_ready = 1'b0;
    #1 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", {o_shake_valid, o_shake_last, o_shake_ack, o_key_valid, o_busy, o_done, o_err}, 0);
    chk("mid_rst_key", o_key, 0);
    chk("mid_rst_data", o_shake_data, 0);
    chk("mid_rst_words_left", exp_w.size(), 2);
    exp_w.delete();
    last_key = '0;
    @(negedge i_clk);
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("post_rst_busy", o_busy, 0);
    full_request(rnd256());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
